// File: rtl/techlib_regbank_arbiter.sv
// rtl/techlib_regbank_arbiter.sv - round-robin write arbiter with burst lock in front of a small flop register bank
module techlib_regbank_arbiter #(
  parameter int               WIDTH       = 8,
  parameter int               NREQ        = 4,
  parameter int               DEPTH       = 4,
  parameter int               AW          = 2,
  parameter int               LOCK_MAX    = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              OW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk_i,
  input  logic                 srst_n_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ-1:0]      lock_i,
  input  logic [NREQ*AW-1:0]   waddr_i,
  input  logic [NREQ*WIDTH-1:0] wdata_i,
  output logic [NREQ-1:0]      gnt_o,
  input  logic [AW-1:0]        raddr_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic                 busy_o,
  output logic [OW-1:0]        owner_o
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e           state_q, state_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] bank_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  logic             rr_found;
  logic [OW-1:0]    rr_idx;
  logic             rr_lock;
  logic             owner_req;
  logic             owner_lock;
  logic             win_valid;
  logic [OW-1:0]    win_idx;
  logic [AW-1:0]    win_addr;
  logic [WIDTH-1:0] win_data;
  logic [WIDTH-1:0] rd_word;

  function automatic logic [OW-1:0] next_ptr(input logic [OW-1:0] idx);
    if (idx == OW'(NREQ - 1)) begin
      return '0;
    end
    return idx + OW'(1);
  endfunction

  // Round-robin pick: first request at or after ptr, then wrap to the indices below ptr
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_lock  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!rr_found && req_i[i] && (OW'(i) >= ptr_q)) begin
        rr_found = 1'b1;
        rr_idx   = OW'(i);
        rr_lock  = lock_i[i];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!rr_found && req_i[i] && (OW'(i) < ptr_q)) begin
        rr_found = 1'b1;
        rr_idx   = OW'(i);
        rr_lock  = lock_i[i];
      end
    end
  end

  // Request and lock qualifiers of the current lock owner
  always_comb begin
    owner_req  = 1'b0;
    owner_lock = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (OW'(i) == owner_q) begin
        owner_req  = req_i[i];
        owner_lock = lock_i[i];
      end
    end
  end

  // FSM state register together with the round-robin pointer and burst counter
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a present locked owner keeps the port, otherwise fall back to round-robin in the same cycle
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    win_valid = 1'b0;
    win_idx   = '0;
    if (state_q == ST_LOCKED && owner_req) begin
      win_valid = 1'b1;
      win_idx   = owner_q;
      ptr_d     = next_ptr(owner_q);
      cnt_d     = cnt_q + CW'(1);
      if (!owner_lock || (cnt_q + CW'(1) == CW'(LOCK_MAX))) begin
        state_d = ST_IDLE;
        owner_d = '0;
        cnt_d   = '0;
      end
    end else begin
      state_d = ST_IDLE;
      owner_d = '0;
      cnt_d   = '0;
      if (rr_found) begin
        win_valid = 1'b1;
        win_idx   = rr_idx;
        ptr_d     = next_ptr(rr_idx);
        if (rr_lock && (LOCK_MAX > 1)) begin
          state_d = ST_LOCKED;
          owner_d = rr_idx;
          cnt_d   = CW'(1);
        end
      end
    end
  end

  // Outputs: one-hot grant suppressed during reset, lock status straight from the state
  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_o[i] = win_valid && srst_n_i && (OW'(i) == win_idx);
    end
    busy_o  = (state_q == ST_LOCKED);
    owner_o = owner_q;
  end

  // Payload of the granted requester
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_o[i]) begin
        win_addr = waddr_i[i*AW +: AW];
        win_data = wdata_i[i*WIDTH +: WIDTH];
      end
    end
  end

  // Read mux; addresses beyond the bank read as zero
  always_comb begin
    rd_word = '0;
    for (int d = 0; d < DEPTH; d++) begin
      if (raddr_i == AW'(d)) begin
        rd_word = bank_q[d];
      end
    end
  end

  // Bank flops and registered read port; reads return the pre-write value on a collision
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      rdata_q <= RESET_VALUE;
      for (int d = 0; d < DEPTH; d++) begin
        bank_q[d] <= RESET_VALUE;
      end
    end else begin
      rdata_q <= rd_word;
      for (int d = 0; d < DEPTH; d++) begin
        if ((|gnt_o) && (win_addr == AW'(d))) begin
          bank_q[d] <= win_data;
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_techlib_regbank_arbiter.sv
// tb/tb_techlib_regbank_arbiter.sv - scoreboard bench for techlib_regbank_arbiter
module tb_techlib_regbank_arbiter;

  logic        clk = 1'b0;
  logic        srst_n = 1'b0;
  logic [3:0]  req = 4'b1111;
  logic [3:0]  lock = 4'b0000;
  logic [7:0]  waddr = 8'b11_10_01_00;
  logic [31:0] wdata = 32'h13121110;
  logic [1:0]  raddr = 2'd0;

  logic [3:0]  gnt0, gnt1;
  logic [7:0]  rdata0, rdata1;
  logic        busy0, busy1;
  logic [1:0]  owner0, owner1;

  always #5 clk = ~clk;

  techlib_regbank_arbiter #(.WIDTH(8), .NREQ(4), .DEPTH(4), .AW(2), .LOCK_MAX(4)) dut0 (
    .clk_i(clk), .srst_n_i(srst_n), .req_i(req), .lock_i(lock), .waddr_i(waddr),
    .wdata_i(wdata), .gnt_o(gnt0), .raddr_i(raddr), .rdata_o(rdata0),
    .busy_o(busy0), .owner_o(owner0)
  );

  techlib_regbank_arbiter #(.WIDTH(8), .NREQ(4), .DEPTH(3), .AW(2), .LOCK_MAX(4)) dut1 (
    .clk_i(clk), .srst_n_i(srst_n), .req_i(req), .lock_i(lock), .waddr_i(waddr),
    .wdata_i(wdata), .gnt_o(gnt1), .raddr_i(raddr), .rdata_o(rdata1),
    .busy_o(busy1), .owner_o(owner1)
  );

  typedef struct {
    bit         sel;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] owner;
    logic [7:0] rdata;
    logic [2:0] chk;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  logic [3:0] m_gnt;
  logic       m_busy;
  logic [1:0] m_owner;
  logic [7:0] m_rdata;

  // Monitor: pop one expectation per cycle and compare away from the rising edge
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e   = sb_q.pop_front();
      m_gnt   = mon_e.sel ? gnt1 : gnt0;
      m_busy  = mon_e.sel ? busy1 : busy0;
      m_owner = mon_e.sel ? owner1 : owner0;
      m_rdata = mon_e.sel ? rdata1 : rdata0;
      if (mon_e.chk[2]) begin
        checks++;
        if (m_gnt !== mon_e.gnt) begin
          failures++;
          $display("FAIL %s gnt got=%b exp=%b", mon_e.name, m_gnt, mon_e.gnt);
        end
      end
      if (mon_e.chk[1]) begin
        checks++;
        if (m_busy !== mon_e.busy || m_owner !== mon_e.owner) begin
          failures++;
          $display("FAIL %s busy/owner got=%b/%0d exp=%b/%0d", mon_e.name, m_busy, m_owner,
                   mon_e.busy, mon_e.owner);
        end
      end
      if (mon_e.chk[0]) begin
        checks++;
        if (m_rdata !== mon_e.rdata) begin
          failures++;
          $display("FAIL %s rdata got=%h exp=%h", mon_e.name, m_rdata, mon_e.rdata);
        end
      end
    end
  end

  task automatic step(input string nm, input logic rn, input logic [3:0] r, input logic [3:0] l,
                      input logic [7:0] wa, input logic [31:0] wd, input logic [1:0] ra,
                      input bit sel, input logic [3:0] eg, input logic eb, input logic [1:0] eo,
                      input logic [7:0] er, input logic [2:0] chk);
    exp_t e;
    @(posedge clk);
    #1;
    srst_n = rn;
    req    = r;
    lock   = l;
    waddr  = wa;
    wdata  = wd;
    raddr  = ra;
    e.sel   = sel;
    e.gnt   = eg;
    e.busy  = eb;
    e.owner = eo;
    e.rdata = er;
    e.chk   = chk;
    e.name  = nm;
    sb_q.push_back(e);
  endtask

  localparam logic [7:0]  WA0  = 8'b11_10_01_00;
  localparam logic [7:0]  WAH  = 8'b11_10_01_11;
  localparam logic [7:0]  WAI  = 8'b11_10_10_11;
  localparam logic [31:0] WD0  = 32'h13121110;
  localparam logic [31:0] WD1  = 32'h13121120;
  localparam logic [31:0] WD2  = 32'h1312AA20;
  localparam logic [31:0] WDH  = 32'h1312AA55;
  localparam logic [31:0] WDI  = 32'h13127755;
  localparam logic [31:0] WDI2 = 32'h13129955;

  initial begin
    // reset with every requester asking
    step("rst1", 0, 4'b1111, 4'b0000, WA0, WD0, 2'd0, 0, 4'b0000, 0, 2'd0, 8'h00, 3'b111);
    step("rst2", 0, 4'b1111, 4'b0000, WA0, WD0, 2'd0, 0, 4'b0000, 0, 2'd0, 8'h00, 3'b111);
    step("rd0",  1, 4'b0000, 4'b0000, WA0, WD0, 2'd0, 0, 4'b0000, 0, 2'd0, 8'h00, 3'b111);
    step("rd1",  1, 4'b0000, 4'b0000, WA0, WD0, 2'd1, 0, 4'b0000, 0, 2'd0, 8'h00, 3'b001);
    step("rd2",  1, 4'b0000, 4'b0000, WA0, WD0, 2'd2, 0, 4'b0000, 0, 2'd0, 8'h00, 3'b001);
    step("rd3",  1, 4'b0000, 4'b0000, WA0, WD0, 2'd3, 0, 4'b0000, 0, 2'd0, 8'h00, 3'b001);
    // plain round robin over all four
    step("rr0",  1, 4'b1111, 4'b0000, WA0, WD0, 2'd0, 0, 4'b0001, 0, 2'd0, 8'h00, 3'b111);
    step("rr1",  1, 4'b1111, 4'b0000, WA0, WD0, 2'd0, 0, 4'b0010, 0, 2'd0, 8'h00, 3'b111);
    step("rr2",  1, 4'b1111, 4'b0000, WA0, WD0, 2'd1, 0, 4'b0100, 0, 2'd0, 8'h10, 3'b111);
    step("rr3",  1, 4'b1111, 4'b0000, WA0, WD0, 2'd2, 0, 4'b1000, 0, 2'd0, 8'h11, 3'b111);
    step("rr4",  1, 4'b1111, 4'b0000, WA0, WD0, 2'd3, 0, 4'b0001, 0, 2'd0, 8'h12, 3'b111);
    step("rr5",  1, 4'b1000, 4'b0000, WA0, WD0, 2'd0, 0, 4'b1000, 0, 2'd0, 8'h13, 3'b111);
    // full locked burst by requester 0
    step("lk0",  1, 4'b0101, 4'b0001, WA0, WD1, 2'd0, 0, 4'b0001, 0, 2'd0, 8'h10, 3'b111);
    step("lk1",  1, 4'b0101, 4'b0001, WA0, WD1, 2'd0, 0, 4'b0001, 1, 2'd0, 8'h10, 3'b111);
    step("lk2",  1, 4'b0101, 4'b0001, WA0, WD1, 2'd0, 0, 4'b0001, 1, 2'd0, 8'h20, 3'b111);
    step("lk3",  1, 4'b0101, 4'b0001, WA0, WD1, 2'd0, 0, 4'b0001, 1, 2'd0, 8'h20, 3'b111);
    step("lk4",  1, 4'b0101, 4'b0001, WA0, WD1, 2'd0, 0, 4'b0100, 0, 2'd0, 8'h20, 3'b111);
    // owner drops request mid-burst
    step("dr0",  1, 4'b0101, 4'b0001, WA0, WD1, 2'd0, 0, 4'b0001, 0, 2'd0, 8'h20, 3'b111);
    step("dr1",  1, 4'b0101, 4'b0001, WA0, WD1, 2'd0, 0, 4'b0001, 1, 2'd0, 8'h20, 3'b111);
    step("dr2",  1, 4'b0100, 4'b0001, WA0, WD1, 2'd0, 0, 4'b0100, 1, 2'd0, 8'h20, 3'b111);
    step("dr3",  1, 4'b0000, 4'b0000, WA0, WD1, 2'd0, 0, 4'b0000, 0, 2'd0, 8'h20, 3'b111);
    // lock by requester 2, released by dropping LOCK
    step("ow0",  1, 4'b0100, 4'b0100, WA0, WD1, 2'd0, 0, 4'b0100, 0, 2'd0, 8'h20, 3'b111);
    step("ow1",  1, 4'b0110, 4'b0000, WA0, WD1, 2'd0, 0, 4'b0100, 1, 2'd2, 8'h20, 3'b111);
    step("ow2",  1, 4'b0010, 4'b0000, WA0, WD1, 2'd0, 0, 4'b0010, 0, 2'd0, 8'h20, 3'b111);
    // same-edge write/read collision
    step("co0",  1, 4'b0010, 4'b0000, WA0, WD2, 2'd1, 0, 4'b0010, 0, 2'd0, 8'h20, 3'b111);
    step("co1",  1, 4'b0000, 4'b0000, WA0, WD2, 2'd1, 0, 4'b0000, 0, 2'd0, 8'h11, 3'b111);
    step("co2",  1, 4'b0000, 4'b0000, WA0, WD2, 2'd1, 0, 4'b0000, 0, 2'd0, 8'hAA, 3'b111);
    // out-of-range address on the DEPTH=3 instance
    step("oa0",  1, 4'b0001, 4'b0000, WAH, WDH, 2'd3, 1, 4'b0001, 0, 2'd0, 8'hAA, 3'b111);
    step("oa1",  1, 4'b0000, 4'b0000, WAH, WDH, 2'd0, 1, 4'b0000, 0, 2'd0, 8'h00, 3'b111);
    step("oa2",  1, 4'b0000, 4'b0000, WAH, WDH, 2'd1, 1, 4'b0000, 0, 2'd0, 8'h20, 3'b001);
    step("oa3",  1, 4'b0000, 4'b0000, WAH, WDH, 2'd2, 1, 4'b0000, 0, 2'd0, 8'hAA, 3'b001);
    step("oa4",  1, 4'b0000, 4'b0000, WAH, WDH, 2'd3, 1, 4'b0000, 0, 2'd0, 8'h12, 3'b001);
    step("oa5",  1, 4'b0000, 4'b0000, WAH, WDH, 2'd0, 0, 4'b0000, 0, 2'd0, 8'h55, 3'b001);
    // reset in the middle of a locked burst
    step("rb0",  1, 4'b0010, 4'b0010, WAI, WDI, 2'd2, 0, 4'b0010, 0, 2'd0, 8'h20, 3'b111);
    step("rb1",  0, 4'b0010, 4'b0010, WAI, WDI2, 2'd2, 0, 4'b0000, 1, 2'd1, 8'h12, 3'b111);
    step("rb2",  1, 4'b1010, 4'b0000, WAI, WDI2, 2'd2, 0, 4'b0010, 0, 2'd0, 8'h00, 3'b111);
    step("rb3",  1, 4'b0000, 4'b0000, WAI, WDI2, 2'd2, 0, 4'b0000, 0, 2'd0, 8'h00, 3'b111);
    step("rb4",  1, 4'b0000, 4'b0000, WAI, WDI2, 2'd2, 0, 4'b0000, 0, 2'd0, 8'h99, 3'b111);
    repeat (3) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending got=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
